// File: rtl/pampy_pkg.sv
// Shared widths and fetch FSM encoding for
// the pampy instruction fetch path.
package pampy_pkg;

  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 12;
  localparam int INSTR_W = 16;
  localparam int FIFO_D  = 2;

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_DISCARD
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small prefetch FIFO with synchronous flush;
// head entry is always visible on dout.
module fetch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_pop;

  function automatic logic [PW-1:0] bump(
    input logic [PW-1:0] p
  );
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign do_pop = pop & ~empty;
  assign full   = (count == FULL_C);
  assign empty  = (count == '0);
  assign dout   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= bump(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= bump(rd_ptr);
      end
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: one-outstanding memory
// handshake feeding a prefetch FIFO to decode.
module instr_fetch_unit
  import pampy_pkg::*;
#(
  parameter int DATA_WIDTH        = DATA_W,
  parameter int ADDR_WIDTH        = ADDR_W,
  parameter int INSTRUCTION_WIDTH = INSTR_W,
  parameter int FIFO_DEPTH        = FIFO_D
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         PC_LOAD,
  input  logic [ADDR_WIDTH-1:0]        PC_LOAD_ADDR,
  output logic                         MEM_REQ,
  output logic [ADDR_WIDTH-1:0]        MEM_ADDR,
  input  logic                         MEM_ACK,
  input  logic [INSTRUCTION_WIDTH-1:0] MEM_DATA_IN,
  output logic                         INSTR_VALID,
  input  logic                         INSTR_READY,
  output logic [DATA_WIDTH-1:0]        INSTR_OUT,
  output logic [DATA_WIDTH-1:0]        ARG_OUT,
  output logic [ADDR_WIDTH-1:0]        INSTR_PC_OUT
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int EW = ADDR_WIDTH + 2 * DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PC_ONE =
    ADDR_WIDTH'(1);
  localparam logic [CW-1:0] DEPTH_C =
    CW'(FIFO_DEPTH);

  fetch_state_t          state;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  ack;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  empty;
  logic                  can_issue;
  logic [CW-1:0]         count;
  logic [CW-1:0]         count_next;
  logic [EW-1:0]         din;
  logic [EW-1:0]         dout;

  assign ack  = MEM_REQ & MEM_ACK;
  assign push = ack & ~PC_LOAD & ~full &
                (state != S_DISCARD);
  assign pop  = ~empty & INSTR_READY;
  assign din  = {MEM_ADDR,
                 MEM_DATA_IN[INSTRUCTION_WIDTH-1 -: DATA_WIDTH],
                 MEM_DATA_IN[DATA_WIDTH-1:0]};

  // Occupancy after this cycle's push/pop gates the next request.
  always_comb begin
    count_next = count + CW'(push) - CW'(pop);
    if (PC_LOAD) begin
      count_next = '0;
    end
  end

  assign can_issue = (count_next < DEPTH_C);

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (push),
    .pop   (pop),
    .flush (PC_LOAD),
    .din   (din),
    .dout  (dout),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign INSTR_VALID = ~empty;
  assign {INSTR_PC_OUT, INSTR_OUT, ARG_OUT} = dout;

  // pc holds the address of the next request to issue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_FETCH;
      pc       <= '0;
      MEM_REQ  <= 1'b0;
      MEM_ADDR <= '0;
    end else if (PC_LOAD) begin
      pc <= PC_LOAD_ADDR;
      if (MEM_REQ && !MEM_ACK) begin
        state <= S_DISCARD;
      end else begin
        state    <= S_FETCH;
        MEM_REQ  <= 1'b1;
        MEM_ADDR <= PC_LOAD_ADDR;
        pc       <= PC_LOAD_ADDR + PC_ONE;
      end
    end else begin
      case (state)
        S_DISCARD: begin
          if (ack) begin
            state    <= S_FETCH;
            MEM_REQ  <= 1'b1;
            MEM_ADDR <= pc;
            pc       <= pc + PC_ONE;
          end
        end
        default: begin
          if (MEM_REQ && !ack) begin
            state <= S_WAIT;
          end else if (can_issue) begin
            state    <= S_FETCH;
            MEM_REQ  <= 1'b1;
            MEM_ADDR <= pc;
            pc       <= pc + PC_ONE;
          end else begin
            state   <= S_FETCH;
            MEM_REQ <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
